// File: rtl/x_matvec_engine_pkg.sv
// Shared constants, FSM state encoding and the issue tag carried alongside
// each outstanding read of the x buffer / coefficient ROM.
package x_matvec_engine_pkg;

    localparam int N_ELEM = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int N_ROWS = 4;
    localparam int ROW_W  = 2;
    localparam int RD_LAT = 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [ROW_W-1:0] row;
    } tag_t;

    function automatic logic [ACC_W-1:0] widen_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/x_matvec_engine_if.sv
// Bus between the matvec engine and its environment: x buffer, coefficient
// ROM and result stream.
interface x_matvec_engine_if;
    import x_matvec_engine_pkg::*;

    logic                    x_ready;
    logic [ADDR_W-1:0]       x_addr;
    logic [DATA_W-1:0]       x_data;
    logic [ROW_W+ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0]       coef_data;
    logic [ACC_W-1:0]        result;
    logic                    result_valid;
    logic [ROW_W-1:0]        result_row;
    logic                    done;

    modport master (
        input  x_ready, x_data, coef_data,
        output x_addr, coef_addr, result, result_valid, result_row, done
    );

    modport slave (
        output x_ready, x_data, coef_data,
        input  x_addr, coef_addr, result, result_valid, result_row, done
    );

endinterface

// File: rtl/x_matvec_engine_mac_accumulator.sv
// Multiply-accumulate stage: loads on the first element of a row, adds
// otherwise, and publishes the row sum with a one-cycle strobe on the last.
module x_matvec_engine_mac_accumulator
    import x_matvec_engine_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  tag_t              tag,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] coef_data,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic [ROW_W-1:0]  result_row
);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  result_reg;
    logic              result_valid_reg;
    logic [ROW_W-1:0]  result_row_reg;

    assign prod = PROD_W'(x_data) * PROD_W'(coef_data);
    assign sum  = acc_reg + widen_prod(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            result_row_reg   <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            if (tag.valid) begin
                // Loading on the first element avoids a separate clear cycle between rows.
                acc_reg <= tag.first ? widen_prod(prod) : sum;
                if (tag.last) begin
                    result_reg       <= sum;
                    result_row_reg   <= tag.row;
                    result_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign result_row   = result_row_reg;

endmodule

// File: rtl/x_matvec_engine.sv
// Matrix-vector engine: streams {row,k} addresses at one per cycle, tags each
// read through an RD_LAT-deep pipeline and accumulates one dot product per row.
module x_matvec_engine
    import x_matvec_engine_pkg::*;
(
    input logic               clk,
    input logic               reset_n,
    x_matvec_engine_if.master bus
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] k_reg, k_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic              row_end;
    logic              last_row;
    tag_t              issue_tag;
    tag_t              tag_pipe [RD_LAT];
    logic [RD_LAT-2:0] pipe_valid;

    assign row_end  = (k_reg == ADDR_W'(N_ELEM - 1));
    assign last_row = (row_reg == ROW_W'(N_ROWS - 1));

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        row_next   = row_reg;
        case (state_reg)
            IDLE: begin
                if (bus.x_ready) state_next = ISSUE;
            end
            ISSUE: begin
                // Counters freeze on the final issue so the addresses hold afterwards.
                if (row_end && last_row) begin
                    state_next = DRAIN;
                end else begin
                    k_next = k_reg + 1'b1;
                    if (row_end) row_next = row_reg + 1'b1;
                end
            end
            DRAIN: begin
                // The last stage is consumed this cycle, so only earlier stages matter.
                if (pipe_valid == '0) state_next = DONE;
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = (state_reg == ISSUE);
        issue_tag.first = (k_reg == '0);
        issue_tag.last  = row_end;
        issue_tag.row   = row_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) tag_pipe[gi] <= '0;
                    else          tag_pipe[gi] <= issue_tag;
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) tag_pipe[gi] <= '0;
                    else          tag_pipe[gi] <= tag_pipe[gi-1];
                end
            end
            if (gi < RD_LAT - 1) begin : g_valid
                assign pipe_valid[gi] = tag_pipe[gi].valid;
            end
        end
    endgenerate

    x_matvec_engine_mac_accumulator u_mac (
        .clk          (clk),
        .reset_n      (reset_n),
        .tag          (tag_pipe[RD_LAT-1]),
        .x_data       (bus.x_data),
        .coef_data    (bus.coef_data),
        .result       (bus.result),
        .result_valid (bus.result_valid),
        .result_row   (bus.result_row)
    );

    assign bus.x_addr    = k_reg;
    assign bus.coef_addr = {row_reg, k_reg};
    assign bus.done      = (state_reg == DONE);

endmodule

// File: tb/tb_x_matvec_engine.sv
// Directed bench for x_matvec_engine: x buffer and coefficient ROM modelled
// as two-stage registered memories, cycle-exact checks of addresses and strobes.
module tb_x_matvec_engine;

    logic clk;
    logic reset_n;

    x_matvec_engine_if bus ();

    x_matvec_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] x_mem [32];
    logic [7:0] a_mem [128];
    logic [7:0] x_d1, x_d2, a_d1, a_d2;

    initial begin
        x_d1 = '0; x_d2 = '0; a_d1 = '0; a_d2 = '0;
    end

    always @(posedge clk) begin
        x_d1 <= x_mem[bus.x_addr];
        x_d2 <= x_d1;
        a_d1 <= a_mem[bus.coef_addr];
        a_d2 <= a_d1;
    end

    assign bus.x_data    = x_d2;
    assign bus.coef_data = a_d2;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    string       test_name = "init";
    int          cur_j = 0;
    logic [31:0] exp_res [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $display("FAIL [%s] %s at c0+%0d: observed %0d expected %0d",
                     test_name, tag, cur_j, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " x_addr"},       32'(bus.x_addr), 32'd0);
        check({tag, " coef_addr"},    32'(bus.coef_addr), 32'd0);
        check({tag, " result"},       32'(bus.result), 32'd0);
        check({tag, " result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, " result_row"},   32'(bus.result_row), 32'd0);
        check({tag, " done"},         32'(bus.done), 32'd0);
    endtask

    // Caller arms the engine at a negedge; the next negedge is cycle c0.
    task automatic check_run(input int n_cyc, input int drop_at);
        logic strobe;
        int   row;
        for (int j = 0; j < n_cyc; j++) begin
            @(negedge clk);
            cur_j = j;
            if (j == drop_at) bus.x_ready = 1'b0;
            if (j < 128) begin
                check("coef_addr", 32'(bus.coef_addr), 32'(j));
                check("x_addr", 32'(bus.x_addr), 32'(j % 32));
            end else begin
                check("coef_addr_hold", 32'(bus.coef_addr), 32'd127);
                check("x_addr_hold", 32'(bus.x_addr), 32'd31);
            end
            strobe = (j >= 34) && (j <= 130) && (((j - 34) % 32) == 0);
            check("result_valid", 32'(bus.result_valid), 32'(strobe));
            if (strobe) begin
                row = (j - 34) / 32;
                check("result_row", 32'(bus.result_row), 32'(row));
                check("result", 32'(bus.result), exp_res[row]);
            end
            check("done", 32'(bus.done), 32'(j >= 130));
        end
    endtask

    task automatic load_pattern_k();
        for (int k = 0; k < 32; k++) begin
            x_mem[k]      = 8'(k);
            a_mem[k]      = 8'd1;
            a_mem[32 + k] = 8'd0;
            a_mem[64 + k] = (k == 5) ? 8'd1 : 8'd0;
            a_mem[96 + k] = 8'd2;
        end
        exp_res[0] = 32'd496;
        exp_res[1] = 32'd0;
        exp_res[2] = 32'd5;
        exp_res[3] = 32'd992;
    endtask

    task automatic load_uniform(input logic [7:0] xv, input logic [7:0] av, input logic [31:0] r);
        for (int k = 0; k < 32; k++) x_mem[k] = xv;
        for (int k = 0; k < 128; k++) a_mem[k] = av;
        for (int r2 = 0; r2 < 4; r2++) exp_res[r2] = r;
    endtask

    task automatic pulse_reset();
        bus.x_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.x_ready = 1'b0;
        load_uniform(8'd1, 8'd1, 32'd32);

        // Reset state
        test_name = "reset";
        repeat (2) @(negedge clk);
        check_outputs_zero("in_reset");
        reset_n = 1'b1;

        // Idle while x_ready is low, then all-ones vectors
        test_name = "ones";
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cur_j = -1;
            check("idle x_addr", 32'(bus.x_addr), 32'd0);
            check("idle result_valid", 32'(bus.result_valid), 32'd0);
            check("idle done", 32'(bus.done), 32'd0);
        end
        bus.x_ready = 1'b1;
        check_run(141, -1);

        // x[k]=k with distinct rows; x_ready already high at reset release
        test_name = "ramp";
        load_pattern_k();
        pulse_reset();
        bus.x_ready = 1'b1;
        check_run(141, -1);

        // Full-scale operands must not wrap
        test_name = "max";
        load_uniform(8'd255, 8'd255, 32'd2080800);
        pulse_reset();
        bus.x_ready = 1'b1;
        check_run(141, -1);

        // Reset in the middle of row 1, then a clean replay
        test_name = "mid_reset";
        load_pattern_k();
        pulse_reset();
        bus.x_ready = 1'b1;
        check_run(41, -1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs_zero("held_reset");
        end
        reset_n = 1'b1;
        test_name = "replay";
        check_run(141, -1);

        // x_ready drops mid-ISSUE, then pulses after done
        test_name = "ready_toggle";
        load_uniform(8'd3, 8'd7, 32'd672);
        pulse_reset();
        bus.x_ready = 1'b1;
        check_run(141, 50);
        test_name = "after_done";
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cur_j = 141 + i;
            bus.x_ready = (i >= 2 && i < 5) ? 1'b1 : 1'b0;
            check("post result_valid", 32'(bus.result_valid), 32'd0);
            check("post done", 32'(bus.done), 32'd1);
            check("post coef_addr", 32'(bus.coef_addr), 32'd127);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
